// File: rtl/cdb_arbiter_if.sv
// Common data bus arbitration bundle: reservation-station requests and results in,
// one-hot retire, broadcast bus and status out.
interface cdb_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RS     = 4
);
  localparam int IDX_W = $clog2(NUM_RS);
  typedef logic [IDX_W-1:0] e_functional_unit;

  logic [NUM_RS-1:0]                 req_i;
  logic [NUM_RS-1:0][DATA_WIDTH-1:0] data_i;
  logic                              stall_i;
  logic [NUM_RS-1:0]                 retire_o;
  logic                              bcast_en_o;
  logic [DATA_WIDTH-1:0]             bcast_data_o;
  e_functional_unit                  bcast_rs_o;
  logic [31:0]                       grant_count_o;
  logic                              starve_err_o;

  modport slave (
    input  req_i, data_i, stall_i,
    output retire_o, bcast_en_o, bcast_data_o, bcast_rs_o, grant_count_o, starve_err_o
  );

  modport master (
    output req_i, data_i, stall_i,
    input  retire_o, bcast_en_o, bcast_data_o, bcast_rs_o, grant_count_o, starve_err_o
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: zero-latency grant of one reservation station per cycle,
// with a saturating grant counter and sticky per-requester starvation detection.
module cdb_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_RS       = 4,
  parameter int STARVE_LIMIT = 15
) (
  input logic         clk,
  input logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_RS);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [IDX_W-1:0]             ptr_q, ptr_d;
  logic [31:0]                  gcnt_q, gcnt_d;
  logic [NUM_RS-1:0][CNT_W-1:0] wait_q, wait_d;
  logic                         starve_q, starve_d;

  logic                  win_vld;
  logic [IDX_W-1:0]      win_idx;
  logic [IDX_W-1:0]      cand;
  logic                  grant;
  logic [NUM_RS-1:0]     retire;
  logic [DATA_WIDTH-1:0] bdata;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_wait(input logic [CNT_W-1:0] v);
    return (v >= LIMIT) ? LIMIT : v + CNT_W'(1);
  endfunction

  // Search from ptr upward, wrapping; first asserted request wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_RS);
      if (!win_vld && bus.req_i[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
    grant = win_vld & ~bus.stall_i & ~rst;
  end

  always_comb begin
    retire   = '0;
    bdata    = '0;
    ptr_d    = ptr_q;
    gcnt_d   = gcnt_q;
    wait_d   = wait_q;
    starve_d = starve_q;
    if (grant) begin
      retire[win_idx] = 1'b1;
      bdata           = bus.data_i[win_idx];
      ptr_d           = (win_idx == IDX_W'(NUM_RS - 1)) ? '0 : win_idx + IDX_W'(1);
      gcnt_d          = sat_inc32(gcnt_q);
    end
    for (int i = 0; i < NUM_RS; i++) begin
      if (wait_q[i] == LIMIT) starve_d = 1'b1;
    end
    // A stalled bus freezes waiting; otherwise a waiting request ages and anything else clears.
    if (!bus.stall_i) begin
      for (int i = 0; i < NUM_RS; i++) begin
        wait_d[i] = (bus.req_i[i] && !retire[i]) ? sat_wait(wait_q[i]) : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      gcnt_q   <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      gcnt_q   <= gcnt_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

  assign bus.retire_o      = retire;
  assign bus.bcast_en_o    = grant;
  assign bus.bcast_data_o  = bdata;
  assign bus.bcast_rs_o    = grant ? win_idx : '0;
  assign bus.grant_count_o = gcnt_q;
  assign bus.starve_err_o  = starve_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, starvation sequence and randomized
// traffic checked against a queue-free behavioural model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int NRS = 4;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.DATA_WIDTH(DW), .NUM_RS(NRS)) ifa ();
  cdb_arbiter_if #(.DATA_WIDTH(DW), .NUM_RS(NRS)) ifb ();

  assign ifb.req_i   = ifa.req_i;
  assign ifb.data_i  = ifa.data_i;
  assign ifb.stall_i = ifa.stall_i;

  cdb_arbiter #(.DATA_WIDTH(DW), .NUM_RS(NRS)) u_dut (
    .clk(clk), .rst(rst), .bus(ifa)
  );

  cdb_arbiter #(.DATA_WIDTH(DW), .NUM_RS(NRS), .STARVE_LIMIT(3)) u_dut_s (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  int n_run  = 0;
  int n_fail = 0;

  // Reference model state: pointer, grant total, unsaturated wait ages, sticky flags.
  int              m_ptr;
  longint unsigned m_gc;
  int              m_wait [NRS];
  bit              m_st_a, m_st_b;

  typedef struct {
    logic        r;
    logic [3:0]  req;
    logic        st;
    logic [3:0]  e_ret;
    logic [1:0]  e_rs;
    logic [31:0] e_gc;
  } vec_t;

  vec_t tbl [18];
  logic [NRS-1:0][DW-1:0] tdata;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_comb(input logic r, input logic [3:0] rq, input logic st,
                            output bit g, output int w);
    bit found;
    found = 1'b0;
    w = 0;
    for (int k = 0; k < NRS; k++) begin
      int i;
      i = (m_ptr + k) % NRS;
      if (!found && rq[i]) begin
        found = 1'b1;
        w = i;
      end
    end
    g = found && !st && !r;
    if (!g) w = 0;
  endtask

  task automatic model_edge(input logic r, input logic [3:0] rq, input logic st,
                            input bit g, input int w);
    if (r) begin
      m_ptr  = 0;
      m_gc   = 0;
      m_st_a = 1'b0;
      m_st_b = 1'b0;
      for (int i = 0; i < NRS; i++) m_wait[i] = 0;
    end else begin
      for (int i = 0; i < NRS; i++) begin
        if (m_wait[i] >= 15) m_st_a = 1'b1;
        if (m_wait[i] >= 3)  m_st_b = 1'b1;
      end
      if (!st) begin
        for (int i = 0; i < NRS; i++)
          m_wait[i] = (rq[i] && !(g && w == i)) ? m_wait[i] + 1 : 0;
      end
      if (g) begin
        m_ptr = (w + 1) % NRS;
        if (m_gc != 64'hFFFF_FFFF) m_gc = m_gc + 1;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] rq, input logic st,
                       input logic [NRS-1:0][DW-1:0] d,
                       output logic [3:0] s_ret, output logic [1:0] s_rs,
                       output logic [31:0] s_gc, output logic [31:0] s_data);
    bit         g;
    int         w;
    logic [3:0] e_ret;
    @(negedge clk);
    rst         = r;
    ifa.req_i   = rq;
    ifa.stall_i = st;
    ifa.data_i  = d;
    #1;
    model_comb(r, rq, st, g, w);
    e_ret = g ? 4'(1 << w) : 4'b0000;
    check("retire",      64'(ifa.retire_o),      64'(e_ret));
    check("bcast_en",    64'(ifa.bcast_en_o),    64'(g));
    check("bcast_data",  64'(ifa.bcast_data_o),  g ? 64'(d[2'(w)]) : 64'd0);
    check("bcast_rs",    64'(ifa.bcast_rs_o),    64'(w));
    check("grant_count", 64'(ifa.grant_count_o), 64'(m_gc));
    check("starve_a",    64'(ifa.starve_err_o),  64'(m_st_a));
    check("starve_b",    64'(ifb.starve_err_o),  64'(m_st_b));
    check("retire_b",    64'(ifb.retire_o),      64'(e_ret));
    s_ret  = ifa.retire_o;
    s_rs   = ifa.bcast_rs_o;
    s_gc   = ifa.grant_count_o;
    s_data = ifa.bcast_data_o;
    @(posedge clk);
    #1;
    model_edge(r, rq, st, g, w);
  endtask

  initial begin
    logic [3:0]  s_ret;
    logic [1:0]  s_rs;
    logic [31:0] s_gc, s_data;
    logic [NRS-1:0][DW-1:0] rd;

    tdata[0] = 32'h1000_0000;
    tdata[1] = 32'h1111_1111;
    tdata[2] = 32'hDEAD_BEEF;
    tdata[3] = 32'h3333_3333;

    //            rst   req      stall e_ret    rs    gc
    tbl[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 32'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 32'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 32'd1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 2'd2, 32'd2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 32'd3};
    tbl[5]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 32'd4};
    tbl[6]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 32'd4};
    tbl[7]  = '{1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 32'd4};
    tbl[8]  = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 32'd5};
    tbl[9]  = '{1'b0, 4'b0011, 1'b0, 4'b0010, 2'd1, 32'd6};
    tbl[10] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 32'd7};
    tbl[11] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 32'd7};
    tbl[12] = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 32'd7};
    tbl[13] = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 32'd7};
    tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 2'd3, 32'd8};
    tbl[15] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 32'd9};
    tbl[16] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 32'd0};
    tbl[17] = '{1'b0, 4'b1111, 1'b0, 4'b0010, 2'd1, 32'd1};

    ifa.req_i   = '0;
    ifa.stall_i = 1'b0;
    ifa.data_i  = '0;
    rst         = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_edge(1'b1, 4'b0000, 1'b0, 1'b0, 0);

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].r, tbl[i].req, tbl[i].st, tdata, s_ret, s_rs, s_gc, s_data);
      check($sformatf("tbl%0d_retire", i), 64'(s_ret), 64'(tbl[i].e_ret));
      check($sformatf("tbl%0d_rs", i),     64'(s_rs),  64'(tbl[i].e_rs));
      check($sformatf("tbl%0d_gc", i),     64'(s_gc),  64'(tbl[i].e_gc));
      check($sformatf("tbl%0d_data", i),   64'(s_data),
            (tbl[i].e_ret != 4'b0000) ? 64'(tdata[tbl[i].e_rs]) : 64'd0);
    end

    // Starvation: with a limit of 3, RS3 ages 3 cycles behind RS0..RS2.
    cycle(1'b1, 4'b1111, 1'b0, tdata, s_ret, s_rs, s_gc, s_data);
    for (int c = 0; c < 3; c++) cycle(1'b0, 4'b1111, 1'b0, tdata, s_ret, s_rs, s_gc, s_data);
    check("starve_b_not_yet", 64'(ifb.starve_err_o), 64'd0);
    cycle(1'b0, 4'b1111, 1'b0, tdata, s_ret, s_rs, s_gc, s_data);
    check("starve_b_set",     64'(ifb.starve_err_o), 64'd1);
    check("starve_a_clear",   64'(ifa.starve_err_o), 64'd0);
    repeat (3) cycle(1'b0, 4'b0000, 1'b0, tdata, s_ret, s_rs, s_gc, s_data);
    check("starve_b_sticky",  64'(ifb.starve_err_o), 64'd1);
    cycle(1'b1, 4'b0000, 1'b0, tdata, s_ret, s_rs, s_gc, s_data);
    check("starve_b_reset",   64'(ifb.starve_err_o), 64'd0);

    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < NRS; i++) rd[i] = $urandom;
      cycle(($urandom_range(0, 49) == 0), 4'($urandom), ($urandom_range(0, 3) == 0), rd,
            s_ret, s_rs, s_gc, s_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the result/broadcast data width.
REQ-002 Parameter NUM_RS, default 4, range 2..16, SHALL set the number of reservation-station requesters.
REQ-003 Parameter STARVE_LIMIT, default 15, SHALL set the unstalled wait cycles at which starvation is flagged.
REQ-004 clk  input  1  clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  NUM_RS  per-RS retirement_ready (result available).
REQ-007 data_i  input  NUM_RS x DATA_WIDTH  per-RS result value.
REQ-008 stall_i  input  1  downstream (regfile/ROB) cannot accept a broadcast this cycle.
REQ-009 retire_o  output  NUM_RS  one-hot grant; drives each RS retire_i.
REQ-010 bcast_en_o  output  1  CDB broadcast valid.
REQ-011 bcast_data_o  output  DATA_WIDTH  broadcast value.
REQ-012 bcast_rs_o  output  e_functional_unit  tag of the broadcasting RS, equal to e_functional_unit'(winner index).
REQ-013 grant_count_o  output  32  total grants since reset (perf counter).
REQ-014 starve_err_o  output  1  sticky starvation error.

Function
REQ-015 Grant SHALL be combinational: retire_o, bcast_en_o, bcast_data_o and bcast_rs_o reflect the same-cycle req_i, stall_i and pointer (zero-latency; the RS retires and the CDB broadcasts in the same cycle).
REQ-016 Arbitration SHALL be round-robin: search indices ptr, ptr+1, ... modulo NUM_RS; the first asserted req_i wins.
REQ-017 At most one retire_o bit SHALL be high per cycle; bcast_en_o SHALL equal |retire_o.
REQ-018 On a grant, ptr SHALL update to (winner+1) mod NUM_RS at the next edge; with no grant ptr SHALL hold.
REQ-019 When stall_i=1, retire_o=0 and bcast_en_o=0, and ptr, grant_count_o and wait counters SHALL hold.
REQ-020 When no grant, bcast_data_o SHALL be 0 and bcast_rs_o SHALL be index 0 (deterministic idle bus).
REQ-021 bcast_data_o SHALL equal data_i[winner] exactly, with no registering or modification.
REQ-022 grant_count_o SHALL increment by 1 per granted cycle and saturate at 32'hFFFF_FFFF.
REQ-023 Each requester i SHALL have a wait counter: increment when req_i[i]=1, retire_o[i]=0, stall_i=0; clear when req_i[i]=0 or retire_o[i]=1; saturate at STARVE_LIMIT.
REQ-024 starve_err_o SHALL set the cycle after any wait counter reaches STARVE_LIMIT and remain set until reset.
REQ-025 Requests dropping without a grant SHALL be tolerated (no state other than wait counter clear).
REQ-026 Wrap-around: winner NUM_RS-1 SHALL set ptr to 0.

Reset
REQ-027 While rst=1, retire_o=0, bcast_en_o=0, bcast_data_o=0, bcast_rs_o=0, regardless of req_i.
REQ-028 At the edge with rst=1: ptr<=0, grant_count_o<=0, all wait counters<=0, starve_err_o<=0; reset mid-stream SHALL drop any pending ordering.

Verification
REQ-029 After reset, req_i=4'b1111 held 4 unstalled cycles -> grants 0,1,2,3 in order, grant_count_o=4, starve_err_o=0.
REQ-030 ptr=2, req_i=4'b0011 -> grant RS0 (retire_o=4'b0001, bcast_rs_o=0, bcast_data_o=data_i[0]); next cycle ptr=1.
REQ-031 req_i=4'b0100, data_i[2]=32'hDEAD_BEEF, stall_i=1 for 3 cycles then 0 -> no grant during stall, bcast_data_o=0; grant RS2 with 32'hDEAD_BEEF on release; ptr unchanged during stall.
REQ-032 req_i=0 -> bcast_en_o=0, bcast_data_o=0, bcast_rs_o=0, grant_count_o unchanged.
REQ-033 Force req_i[1] high while retire_o[1] masked by bench override of data path (STARVE_LIMIT=3, requesters 0 and 2 only granted via injected stall-free forced grants model) -> starve_err_o=1 after 3 unstalled waits, held until rst.
REQ-034 rst asserted for 1 cycle mid-stream with req_i=4'b1111 -> outputs 0 during rst, next grant RS0, grant_count_o restarts at 1.
